// File: rtl/execute_stage_pipelined.sv
// Pipelined MIPS execute stage: ALU, EX/MEM register, iterative mul/div with HI/LO.
// Define EXEC_FORWARD_EN to enable operand forwarding from EX/MEM and WB.
module execute_stage_pipelined #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Flush,
  input  logic              InValid,
  output logic              Stall,
  input  logic              RegWrite,
  input  logic              MemToReg,
  input  logic              MemWrite,
  input  logic              ALUSrc,
  input  logic              RegDst,
  input  logic [3:0]        ALUControl,
  input  logic [2:0]        MdOp,
  input  logic [WIDTH-1:0]  RegSrcA,
  input  logic [WIDTH-1:0]  RegSrcB,
  input  logic [WIDTH-1:0]  ImmIn,
  input  logic [REG_AW-1:0] RsAddr,
  input  logic [REG_AW-1:0] RtDest,
  input  logic [REG_AW-1:0] RdDest,
  input  logic              WbRegWrite,
  input  logic [REG_AW-1:0] WbWriteReg,
  input  logic [WIDTH-1:0]  WbResult,
  output logic              OutValid,
  output logic              RegWriteOut,
  output logic              MemToRegOut,
  output logic              MemWriteOut,
  output logic [WIDTH-1:0]  ALUResult,
  output logic [WIDTH-1:0]  WriteData,
  output logic [REG_AW-1:0] WriteReg
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH);

  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MFHI  = 3'd5;
  localparam logic [2:0] MD_MFLO  = 3'd6;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} md_state_e;

  logic [WIDTH-1:0] fwd_a;
  logic [WIDTH-1:0] fwd_b;

`ifdef EXEC_FORWARD_EN
  logic exmem_fwd_ok;
  assign exmem_fwd_ok = RegWriteOut && OutValid && !MemToRegOut;

  always_comb begin
    fwd_a = RegSrcA;
    if (exmem_fwd_ok && (WriteReg == RsAddr) && (RsAddr != '0))
      fwd_a = ALUResult;
    else if (WbRegWrite && (WbWriteReg == RsAddr) && (RsAddr != '0))
      fwd_a = WbResult;
  end

  always_comb begin
    fwd_b = RegSrcB;
    if (exmem_fwd_ok && (WriteReg == RtDest) && (RtDest != '0))
      fwd_b = ALUResult;
    else if (WbRegWrite && (WbWriteReg == RtDest) && (RtDest != '0))
      fwd_b = WbResult;
  end
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{RsAddr, WbRegWrite, WbWriteReg, WbResult};
  assign fwd_a = RegSrcA;
  assign fwd_b = RegSrcB;
`endif

  // ALU
  logic [WIDTH-1:0] op_b;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;

  assign op_b  = ALUSrc ? ImmIn : fwd_b;
  assign shamt = ImmIn[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (ALUControl)
      4'd0:    alu_res = fwd_a & op_b;
      4'd1:    alu_res = fwd_a | op_b;
      4'd2:    alu_res = fwd_a + op_b;
      4'd3:    alu_res = fwd_a ^ op_b;
      4'd4:    alu_res = ~(fwd_a | op_b);
      4'd6:    alu_res = fwd_a - op_b;
      4'd7:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
      4'd8:    alu_res = {{(WIDTH-1){1'b0}}, (fwd_a < op_b)};
      4'd9:    alu_res = fwd_b << shamt;
      4'd10:   alu_res = fwd_b >> shamt;
      4'd11:   alu_res = $signed(fwd_b) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  // Mul/div control
  md_state_e        state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] acc_hi_reg, acc_lo_reg, opnd_reg;
  logic             is_mul_reg, neg_res_reg, neg_rem_reg, div0_reg;
  logic [WIDTH-1:0] hi_reg, lo_reg;
  logic             md_start, hilo_write;
  logic             md_arith, is_mul_op, signed_op;

  assign md_arith  = (MdOp >= MD_MULT) && (MdOp <= MD_DIVU);
  assign is_mul_op = (MdOp == MD_MULT) || (MdOp == MD_MULTU);
  assign signed_op = (MdOp == MD_MULT) || (MdOp == MD_DIV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    md_start   = 1'b0;
    hilo_write = 1'b0;
    Stall      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (InValid && md_arith && !Flush) begin
          md_start   = 1'b1;
          Stall      = 1'b1;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (Flush) begin
          state_next = ST_IDLE;
        end else begin
          Stall = 1'b1;
          if (cnt_reg == CW'(WIDTH - 1)) state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        hilo_write = !Flush;
      end
      default: state_next = ST_IDLE;
    endcase
    if (!rst_n) Stall = 1'b0;
  end

  // Signed ops run on magnitudes; the sign is restored when HI/LO are written.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, rem_sh, div_diff;

  assign a_neg    = signed_op && fwd_a[WIDTH-1];
  assign b_neg    = signed_op && fwd_b[WIDTH-1];
  assign a_mag    = a_neg ? -fwd_a : fwd_a;
  assign b_mag    = b_neg ? -fwd_b : fwd_b;
  assign mul_sum  = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opnd_reg} : '0);
  assign rem_sh   = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
  assign div_diff = rem_sh - {1'b0, opnd_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      acc_hi_reg  <= '0;
      acc_lo_reg  <= '0;
      opnd_reg    <= '0;
      is_mul_reg  <= 1'b0;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      div0_reg    <= 1'b0;
    end else if (md_start) begin
      cnt_reg     <= '0;
      acc_hi_reg  <= '0;
      acc_lo_reg  <= a_mag;
      opnd_reg    <= b_mag;
      is_mul_reg  <= is_mul_op;
      neg_res_reg <= a_neg ^ b_neg;
      neg_rem_reg <= a_neg;
      div0_reg    <= (fwd_b == '0);
    end else if (state_reg == ST_BUSY && !Flush) begin
      cnt_reg <= cnt_reg + CW'(1);
      if (is_mul_reg) begin
        acc_hi_reg <= mul_sum[WIDTH:1];
        acc_lo_reg <= {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
      end else if (!div_diff[WIDTH]) begin
        acc_hi_reg <= div_diff[WIDTH-1:0];
        acc_lo_reg <= {acc_lo_reg[WIDTH-2:0], 1'b1};
      end else begin
        acc_hi_reg <= rem_sh[WIDTH-1:0];
        acc_lo_reg <= {acc_lo_reg[WIDTH-2:0], 1'b0};
      end
    end
  end

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   md_hi, md_lo;

  always_comb begin
    prod  = {acc_hi_reg, acc_lo_reg};
    if (neg_res_reg) prod = -prod;
    md_hi = prod[2*WIDTH-1:WIDTH];
    md_lo = prod[WIDTH-1:0];
    if (!is_mul_reg) begin
      md_lo = neg_res_reg ? -acc_lo_reg : acc_lo_reg;
      md_hi = neg_rem_reg ? -acc_hi_reg : acc_hi_reg;
      if (div0_reg) md_lo = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (hilo_write) begin
      hi_reg <= md_hi;
      lo_reg <= md_lo;
    end
  end

  // EX/MEM register
  logic [WIDTH-1:0] ex_result;
  assign ex_result = (MdOp == MD_MFHI) ? hi_reg :
                     (MdOp == MD_MFLO) ? lo_reg : alu_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      OutValid    <= 1'b0;
      RegWriteOut <= 1'b0;
      MemToRegOut <= 1'b0;
      MemWriteOut <= 1'b0;
      ALUResult   <= '0;
      WriteData   <= '0;
      WriteReg    <= '0;
    end else if (Flush || !Stall) begin
      OutValid    <= InValid && !Flush;
      RegWriteOut <= InValid && !Flush && RegWrite && !md_arith;
      MemToRegOut <= InValid && !Flush && MemToReg && !md_arith;
      MemWriteOut <= InValid && !Flush && MemWrite && !md_arith;
      ALUResult   <= ex_result;
      WriteData   <= fwd_b;
      WriteReg    <= RegDst ? RdDest : RtDest;
    end
  end

endmodule

// File: tb/tb_execute_stage_pipelined.sv
// Directed bench for execute_stage_pipelined with a scoreboard of expected EX/MEM contents.
module tb_execute_stage_pipelined;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic Flush, InValid, Stall;
  logic RegWrite, MemToReg, MemWrite, ALUSrc, RegDst;
  logic [3:0] ALUControl;
  logic [2:0] MdOp;
  logic [W-1:0] RegSrcA, RegSrcB, ImmIn;
  logic [4:0] RsAddr, RtDest, RdDest;
  logic WbRegWrite;
  logic [4:0] WbWriteReg;
  logic [W-1:0] WbResult;
  logic OutValid, RegWriteOut, MemToRegOut, MemWriteOut;
  logic [W-1:0] ALUResult, WriteData;
  logic [4:0] WriteReg;

  always #5 clk = ~clk;

  execute_stage_pipelined #(.WIDTH(W), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .Flush(Flush), .InValid(InValid), .Stall(Stall),
    .RegWrite(RegWrite), .MemToReg(MemToReg), .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegDst(RegDst),
    .ALUControl(ALUControl), .MdOp(MdOp), .RegSrcA(RegSrcA), .RegSrcB(RegSrcB), .ImmIn(ImmIn),
    .RsAddr(RsAddr), .RtDest(RtDest), .RdDest(RdDest),
    .WbRegWrite(WbRegWrite), .WbWriteReg(WbWriteReg), .WbResult(WbResult),
    .OutValid(OutValid), .RegWriteOut(RegWriteOut), .MemToRegOut(MemToRegOut), .MemWriteOut(MemWriteOut),
    .ALUResult(ALUResult), .WriteData(WriteData), .WriteReg(WriteReg)
  );

  typedef struct {
    logic v, rw, mw, mtr, data;
    logic [W-1:0] res, wd;
    logic [4:0] wr;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [3:0] alu, input logic [2:0] md, input logic [W-1:0] a, b, imm,
                       input logic src, input logic [4:0] rs, rt, rd, input logic dst, rw, mw);
    InValid = 1'b1; ALUControl = alu; MdOp = md;
    RegSrcA = a; RegSrcB = b; ImmIn = imm; ALUSrc = src;
    RsAddr = rs; RtDest = rt; RdDest = rd; RegDst = dst;
    RegWrite = rw; MemWrite = mw; MemToReg = 1'b0;
  endtask

  task automatic collect(input string tag);
    exp_t e;
    @(posedge clk); #1;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, " OutValid"}, 64'(OutValid), 64'(e.v));
      chk({tag, " RegWriteOut"}, 64'(RegWriteOut), 64'(e.rw));
      chk({tag, " MemWriteOut"}, 64'(MemWriteOut), 64'(e.mw));
      chk({tag, " MemToRegOut"}, 64'(MemToRegOut), 64'(e.mtr));
      if (e.data) begin
        chk({tag, " ALUResult"}, 64'(ALUResult), 64'(e.res));
        chk({tag, " WriteData"}, 64'(WriteData), 64'(e.wd));
        chk({tag, " WriteReg"}, 64'(WriteReg), 64'(e.wr));
      end
      $display("txn %-16s valid=%b rw=%b mw=%b res=%h wd=%h wr=%0d",
               tag, OutValid, RegWriteOut, MemWriteOut, ALUResult, WriteData, WriteReg);
    end
  endtask

  task automatic push_bubble();
    exp_t e;
    e.v = 1'b0; e.rw = 1'b0; e.mw = 1'b0; e.mtr = 1'b0; e.data = 1'b0;
    e.res = '0; e.wd = '0; e.wr = '0;
    exp_q.push_back(e);
  endtask

  task automatic txn(input string tag, input logic [3:0] alu, input logic [2:0] md,
                     input logic [W-1:0] a, b, imm, input logic src, input logic [4:0] rs, rt, rd,
                     input logic dst, rw, mw, input logic [W-1:0] exp_res, exp_wd);
    exp_t e;
    drive(alu, md, a, b, imm, src, rs, rt, rd, dst, rw, mw);
    e.v = 1'b1; e.rw = rw; e.mw = mw; e.mtr = 1'b0; e.data = 1'b1;
    e.res = exp_res; e.wd = exp_wd; e.wr = dst ? rd : rt;
    exp_q.push_back(e);
    collect(tag);
  endtask

  task automatic alu_rr(input string tag, input logic [3:0] alu, input logic [W-1:0] a, b,
                        input logic [4:0] rd, input logic [W-1:0] exp_res);
    txn(tag, alu, 3'd0, a, b, '0, 1'b0, 5'd1, 5'd2, rd, 1'b1, 1'b1, 1'b0, exp_res, b);
  endtask

  task automatic mfx(input string tag, input logic [2:0] md, input logic [W-1:0] exp_res);
    txn(tag, 4'd0, md, '0, '0, '0, 1'b0, 5'd1, 5'd2, 5'd12, 1'b1, 1'b1, 1'b0, exp_res, '0);
  endtask

  task automatic md_txn(input string tag, input logic [2:0] op, input logic [W-1:0] a, b,
                        input logic [W-1:0] exp_hi, exp_lo);
    int n;
    exp_t e;
    drive(4'd0, op, a, b, '0, 1'b0, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 1'b0);
    #1;
    chk({tag, " issue Stall"}, 64'(Stall), 64'd1);
    n = 0;
    while (Stall === 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " stall cycles"}, 64'(n), 64'(W + 1));
    e.v = 1'b1; e.rw = 1'b0; e.mw = 1'b0; e.mtr = 1'b0; e.data = 1'b0;
    e.res = '0; e.wd = '0; e.wr = '0;
    exp_q.push_back(e);
    collect({tag, " done"});
    mfx({tag, " MFLO"}, 3'd6, exp_lo);
    mfx({tag, " MFHI"}, 3'd5, exp_hi);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1; Flush = 1'b0; InValid = 1'b0;
    RegWrite = 0; MemToReg = 0; MemWrite = 0; ALUSrc = 0; RegDst = 0;
    ALUControl = '0; MdOp = '0; RegSrcA = '0; RegSrcB = '0; ImmIn = '0;
    RsAddr = '0; RtDest = '0; RdDest = '0;
    WbRegWrite = 1'b0; WbWriteReg = '0; WbResult = '0;
    #1 rst_n = 1'b0;
    InValid = 1'b1; MdOp = 3'd1;
    #11;
    chk("reset Stall", 64'(Stall), 64'd0);
    chk("reset OutValid", 64'(OutValid), 64'd0);
    chk("reset RegWriteOut", 64'(RegWriteOut), 64'd0);
    chk("reset ALUResult", 64'(ALUResult), 64'd0);
    chk("reset WriteReg", 64'(WriteReg), 64'd0);
    InValid = 1'b0; MdOp = 3'd0;
    @(negedge clk); rst_n = 1'b1;

    alu_rr("ADD wrap", 4'd2, 32'h7FFF_FFFF, 32'h1, 5'd8, 32'h8000_0000);
    txn("SUB imm", 4'd6, 3'd0, 32'd5, 32'h1234, 32'd7, 1'b1, 5'd1, 5'd9, 5'd8, 1'b0, 1'b1, 1'b0,
        32'hFFFF_FFFE, 32'h1234);
    txn("SRA", 4'd11, 3'd0, '0, 32'h8000_0000, 32'd4, 1'b0, 5'd1, 5'd2, 5'd10, 1'b1, 1'b1, 1'b0,
        32'hF800_0000, 32'h8000_0000);
    txn("SLL", 4'd9, 3'd0, '0, 32'h1, 32'h3F, 1'b0, 5'd1, 5'd2, 5'd10, 1'b1, 1'b1, 1'b0,
        32'h8000_0000, 32'h1);
    txn("SRL", 4'd10, 3'd0, '0, 32'h8000_0000, 32'd31, 1'b0, 5'd1, 5'd2, 5'd10, 1'b1, 1'b1, 1'b0,
        32'h1, 32'h8000_0000);
    alu_rr("SLT", 4'd7, 32'hFFFF_FFFF, 32'h1, 5'd11, 32'h1);
    alu_rr("SLTU", 4'd8, 32'hFFFF_FFFF, 32'h1, 5'd11, 32'h0);
    alu_rr("AND", 4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd13, 32'hF000_F000);
    alu_rr("OR", 4'd1, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd13, 32'hFFF0_FFF0);
    alu_rr("XOR", 4'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd13, 32'h0FF0_0FF0);
    alu_rr("NOR", 4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd13, 32'h000F_000F);
    alu_rr("undef op", 4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd13, 32'h0);
    txn("store", 4'd2, 3'd0, 32'd100, 32'hCAFE_BABE, 32'd8, 1'b1, 5'd1, 5'd2, 5'd13, 1'b0, 1'b0, 1'b1,
        32'd108, 32'hCAFE_BABE);
    InValid = 1'b0;
    push_bubble();
    collect("bubble");

    md_txn("MULT", 3'd1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    md_txn("MULTU", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    md_txn("DIV", 3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    md_txn("DIV negdiv", 3'd3, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD);
    md_txn("DIV min", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    md_txn("DIVU by0", 3'd4, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);

    drive(4'd0, 3'd4, 32'd100, 32'd7, '0, 1'b0, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("flush issue Stall", 64'(Stall), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    Flush = 1'b1;
    #1;
    chk("flush Stall drop", 64'(Stall), 64'd0);
    push_bubble();
    collect("flush");
    Flush = 1'b0;
    mfx("flush MFHI", 3'd5, 32'd5);
    mfx("flush MFLO", 3'd6, 32'hFFFF_FFFF);

`ifdef EXEC_FORWARD_EN
    txn("FWD base", 4'd2, 3'd0, 32'd10, 32'd20, '0, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 32'd30, 32'd20);
    txn("FWD exmem", 4'd6, 3'd0, 32'd999, 32'd5, '0, 1'b0, 5'd3, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 32'd25, 32'd5);
    WbRegWrite = 1'b1; WbWriteReg = 5'd3; WbResult = 32'd77;
    txn("FWD prio", 4'd2, 3'd0, 32'd999, 32'd1, '0, 1'b0, 5'd3, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0, 32'd26, 32'd1);
    WbWriteReg = 5'd5; WbResult = 32'd40;
    txn("FWD wb", 4'd2, 3'd0, 32'd0, 32'd2, '0, 1'b0, 5'd5, 5'd2, 5'd6, 1'b1, 1'b1, 1'b0, 32'd42, 32'd2);
    WbRegWrite = 1'b0;
    txn("FWD r0 dest", 4'd2, 3'd0, 32'd5, 32'd0, '0, 1'b0, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 32'd5, 32'd0);
    WbRegWrite = 1'b1; WbWriteReg = 5'd0; WbResult = 32'd55;
    txn("FWD r0 src", 4'd2, 3'd0, 32'd100, 32'd1, '0, 1'b0, 5'd0, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0, 32'd101, 32'd1);
    WbRegWrite = 1'b0;
    txn("FWD rt", 4'd6, 3'd0, 32'd50, 32'd0, '0, 1'b0, 5'd1, 5'd7, 5'd8, 1'b1, 1'b1, 1'b0,
        32'hFFFF_FFCD, 32'd101);
`else
    WbRegWrite = 1'b1; WbWriteReg = 5'd1; WbResult = 32'hDEAD;
    alu_rr("WB ignored", 4'd2, 32'd3, 32'd4, 5'd14, 32'd7);
    WbRegWrite = 1'b0;
`endif

    drive(4'd0, 3'd1, 32'd3, 32'd5, '0, 1'b0, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset Stall", 64'(Stall), 64'd0);
    chk("midreset OutValid", 64'(OutValid), 64'd0);
    chk("midreset RegWriteOut", 64'(RegWriteOut), 64'd0);
    chk("midreset ALUResult", 64'(ALUResult), 64'd0);
    chk("midreset WriteData", 64'(WriteData), 64'd0);
    chk("midreset WriteReg", 64'(WriteReg), 64'd0);
    InValid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mfx("midreset MFLO", 3'd6, 32'd0);
    mfx("midreset MFHI", 3'd5, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/execute_stage_pipelined.md
Name: execute_stage_pipelined

Overview:
- Parametrised successor to the single-cycle execute stage.
- Adds an internal EX/MEM output register with a valid bit, and operand forwarding from its own EX/MEM register and from WB.
- Adds an iterative multiply/divide unit with HI/LO registers that stalls upstream while busy.
- Sits between the ID/EX register and the memory stage of the 5-stage MIPS pipeline.

Parameters:
- WIDTH, 32, datapath width in bits (>=8, even).
- REG_AW, 5, register-file address width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Flush  in  1  kill the instruction in EX and abort mul/div.
- InValid  in  1  ID/EX holds a real instruction.
- Stall  out  1  hold ID/EX and earlier stages.
- RegWrite, MemToReg, MemWrite, ALUSrc, RegDst  in  1 each  decoded control.
- ALUControl  in  4  ALU op. Encoding: 0 AND, 1 OR, 2 ADD, 3 XOR, 4 NOR, 6 SUB, 7 SLT, 8 SLTU, 9 SLL, 10 SRL, 11 SRA; others yield 0.
- MdOp  in  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO; 7 treated as none.
- RegSrcA, RegSrcB, ImmIn  in  WIDTH  rs value, rt value, extended immediate.
- RsAddr, RtDest, RdDest  in  REG_AW  source and destination register numbers.
- WbRegWrite  in  1  WB stage writes the register file.
- WbWriteReg  in  REG_AW  WB destination register.
- WbResult  in  WIDTH  WB write-back value.
- OutValid, RegWriteOut, MemToRegOut, MemWriteOut  out  1 each  registered EX/MEM control.
- ALUResult, WriteData  out  WIDTH  registered result and store data.
- WriteReg  out  REG_AW  registered destination.

Behaviour:
- Reset (rst_n low, asynchronous) clears:
  - all outputs to 0;
  - HI, LO and the mul/div counter and state to 0;
  - mul/div FSM to IDLE.
- Stall is 0 during reset.
- ALU-class instructions have 1-cycle latency. Inputs are accepted in cycle T when Stall=0; EX/MEM outputs are valid after the edge ending T.
- Operand B = ImmIn if ALUSrc=1, else the forwarded rt value.
- WriteReg = RdDest if RegDst=1, else RtDest.
- Shift amount = ImmIn[log2(WIDTH)-1:0], shifting the forwarded rt value.
- ADD and SUB wrap modulo 2^WIDTH; no overflow trap.
- SLT and SLTU produce 1 or 0, zero-extended.
- Bubble (InValid=0 or Flush=1): OutValid, RegWriteOut, MemWriteOut and MemToRegOut are loaded 0. Data outputs are don't-care but must be registered.
- MFHI and MFLO put HI or LO on ALUResult with 1-cycle latency.
- Mul/div FSM, IDLE -> BUSY -> DONE -> IDLE:
  - IDLE -> BUSY on InValid & ~Flush & MdOp in 1..4. Operands are latched and Stall rises combinationally in that same cycle.
  - BUSY runs exactly WIDTH cycles: shift-add for multiply, restoring division for divide; one bit per cycle.
  - DONE lasts one cycle, with Stall=0. HI/LO are written at the end of DONE. The instruction enters EX/MEM as OutValid=1 with RegWriteOut=0 and MemWriteOut=0.
- Total issue-to-release is WIDTH+1 stalled cycles.
- MULT/MULTU: {HI,LO} = full 2*WIDTH product, signed or unsigned.
- DIV/DIVU: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
- Divide by zero: LO = all ones, HI = dividend.
- Signed MIN / -1: LO = MIN, HI = 0.
- Stall holds the EX/MEM register unchanged, except in the DONE cycle.
- Flush while BUSY or DONE:
  - FSM returns to IDLE next edge and HI/LO are unchanged.
  - Stall drops combinationally in the Flush cycle.
  - EX/MEM is loaded with a bubble.
- Flush has priority over Stall and new issue.

Optional Feature:
EXEC_FORWARD_EN:
- Defined: the rs and rt operands are forwarded, checked in priority order:
  1. EX/MEM hit: RegWriteOut & OutValid & ~MemToRegOut & WriteReg==addr & addr!=0 gives ALUResult.
  2. Else WB hit: WbRegWrite & WbWriteReg==addr & addr!=0 gives WbResult.
  3. Else the raw register value.
- rt forwarding also feeds WriteData and mul/div operand latching.
- Undefined: RegSrcA and RegSrcB are used directly, and the Wb* ports are ignored.

Test Plan:
- ADD, WIDTH=32: A=0x7FFFFFFF, B=1 -> ALUResult 0x80000000 one cycle later, OutValid=1.
- SRA: rt=0x80000000, ImmIn[4:0]=4 -> ALUResult 0xF8000000.
- MULT: -3 x 7 -> Stall high for exactly 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB. A following MFLO yields 0xFFFFFFEB.
- DIV: -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 5 / 0 -> LO=0xFFFFFFFF, HI=5.
- Forwarding (macro on): ADD r3 followed by SUB using r3 -> second result uses the EX/MEM value. Same register pending in both EX/MEM and WB -> EX/MEM value wins. Destination r0 is never forwarded.
- Flush at cycle 10 of a DIV -> Stall low the same cycle, OutValid=0 next edge, HI/LO unchanged. rst_n low mid-BUSY -> all outputs and HI/LO are 0 immediately.
